alu_issue_stage: RTL



---
 rtl/alu_issue_stage_if.sv | 35 +++
 rtl/alu_issue_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage_if.sv
// Issue-stage bus: upstream (ID) handshake + operands in, execute-side op out.
// slave is the issue stage's view, master is the view of whatever drives it.
interface alu_issue_stage_if #(
  parameter int unsigned XLEN = 32
);
  // Upstream side
  logic            i_valid;
  logic            o_ready;
  logic [31:0]     i_instr;
  logic [XLEN-1:0] i_pc;
  logic [XLEN-1:0] i_rs1_data;
  logic [XLEN-1:0] i_rs2_data;
  logic            i_flush;
  // Execute side
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_alu_in1;
  logic [XLEN-1:0] o_alu_in2;
  logic [4:0]      o_alu_control;
  logic [4:0]      o_rd;
  logic            o_reg_write;
  logic            o_illegal;

  modport slave (
    input  i_valid, i_instr, i_pc, i_rs1_data, i_rs2_data, i_flush, i_ready,
    output o_ready, o_valid, o_alu_in1, o_alu_in2, o_alu_control, o_rd, o_reg_write,
           o_illegal
  );

  modport master (
    output i_valid, i_instr, i_pc, i_rs1_data, i_rs2_data, i_flush, i_ready,
    input  o_ready, o_valid, o_alu_in1, o_alu_in2, o_alu_control, o_rd, o_reg_write,
           o_illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes RV32I OP / OP-IMM / LUI / AUIPC into ALU operands and a
// 5-bit control code, registered toward execute behind a valid/ready skid-less stage.
// Optional performance counters are enabled with the macro ALU_ISSUE_PERF_CNT_EN.
module alu_issue_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
`ifdef ALU_ISSUE_PERF_CNT_EN
  input  logic        i_cnt_clr,
  output logic [31:0] o_issue_cnt,
  output logic [31:0] o_stall_cnt,
`endif
  alu_issue_stage_if.slave bus
);

  localparam logic [4:0] CtlAdd  = 5'b00000;
  localparam logic [4:0] CtlAnd  = 5'b00001;
  localparam logic [4:0] CtlOr   = 5'b00010;
  localparam logic [4:0] CtlXor  = 5'b00011;
  localparam logic [4:0] CtlSll  = 5'b00100;
  localparam logic [4:0] CtlSrl  = 5'b00101;
  localparam logic [4:0] CtlSra  = 5'b00110;
  localparam logic [4:0] CtlSub  = 5'b10000;
  localparam logic [4:0] CtlSlt  = 5'b10111;
  localparam logic [4:0] CtlSltu = 5'b11000;

  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcLui   = 7'b0110111;
  localparam logic [6:0] OpcAuipc = 7'b0010111;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  // Instruction fields
  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt_imm;
  logic [XLEN-1:0] shamt_reg;

  assign opcode    = bus.i_instr[6:0];
  assign rd        = bus.i_instr[11:7];
  assign funct3    = bus.i_instr[14:12];
  assign funct7    = bus.i_instr[31:25];
  assign imm_i     = {{(XLEN-12){bus.i_instr[31]}}, bus.i_instr[31:20]};
  assign imm_u     = {bus.i_instr[31:12], 12'b0};
  // The ALU shifts by the whole operand, so shift amounts are cleared above bit 4 here.
  assign shamt_imm = {{(XLEN-5){1'b0}}, bus.i_instr[24:20]};
  assign shamt_reg = {{(XLEN-5){1'b0}}, bus.i_rs2_data[4:0]};

  // Decoded next-state values
  logic [XLEN-1:0] in1_d;
  logic [XLEN-1:0] in2_d;
  logic [4:0]      ctrl_d;
  logic            illegal_d;
  logic            reg_write_d;

  // Registered outputs
  logic            valid_q;
  logic [XLEN-1:0] in1_q;
  logic [XLEN-1:0] in2_q;
  logic [4:0]      ctrl_q;
  logic [4:0]      rd_q;
  logic            reg_write_q;
  logic            illegal_q;

  logic accept;

  // Decode the incoming instruction into operands and control code
  always_comb begin
    in1_d     = '0;
    in2_d     = '0;
    ctrl_d    = CtlAdd;
    illegal_d = 1'b0;
    unique case (opcode)
      OpcOp: begin
        in1_d = bus.i_rs1_data;
        in2_d = bus.i_rs2_data;
        if (funct7 == F7Base) begin
          unique case (funct3)
            3'b000: ctrl_d = CtlAdd;
            3'b001: begin
              ctrl_d = CtlSll;
              in2_d  = shamt_reg;
            end
            3'b010: ctrl_d = CtlSlt;
            3'b011: ctrl_d = CtlSltu;
            3'b100: ctrl_d = CtlXor;
            3'b101: begin
              ctrl_d = CtlSrl;
              in2_d  = shamt_reg;
            end
            3'b110: ctrl_d = CtlOr;
            default: ctrl_d = CtlAnd;
          endcase
        end else if (funct7 == F7Alt && funct3 == 3'b000) begin
          ctrl_d = CtlSub;
        end else if (funct7 == F7Alt && funct3 == 3'b101) begin
          ctrl_d = CtlSra;
          in2_d  = shamt_reg;
        end else begin
          illegal_d = 1'b1;
        end
      end
      OpcOpImm: begin
        in1_d = bus.i_rs1_data;
        in2_d = imm_i;
        unique case (funct3)
          3'b000: ctrl_d = CtlAdd;
          3'b001: begin
            ctrl_d    = CtlSll;
            in2_d     = shamt_imm;
            illegal_d = (funct7 != F7Base);
          end
          3'b010: ctrl_d = CtlSlt;
          3'b011: ctrl_d = CtlSltu;
          3'b100: ctrl_d = CtlXor;
          3'b101: begin
            // Bit 30 picks arithmetic; any other upper bits make the encoding malformed.
            ctrl_d    = bus.i_instr[30] ? CtlSra : CtlSrl;
            in2_d     = shamt_imm;
            illegal_d = (funct7 != F7Base) && (funct7 != F7Alt);
          end
          3'b110: ctrl_d = CtlOr;
          default: ctrl_d = CtlAnd;
        endcase
      end
      OpcLui: begin
        in1_d = '0;
        in2_d = imm_u;
      end
      OpcAuipc: begin
        in1_d = bus.i_pc;
        in2_d = imm_u;
      end
      default: illegal_d = 1'b1;
    endcase
    // Illegal ops still issue, but as an inert ADD 0,0 that writes nothing.
    if (illegal_d) begin
      in1_d  = '0;
      in2_d  = '0;
      ctrl_d = CtlAdd;
    end
    reg_write_d = !illegal_d && (rd != 5'd0);
  end

  assign bus.o_ready = !valid_q || bus.i_ready;
  assign accept      = bus.i_valid && bus.o_ready;

  // Output register: flush beats accept; payload only changes on accept
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q     <= 1'b0;
      in1_q       <= '0;
      in2_q       <= '0;
      ctrl_q      <= CtlAdd;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (bus.i_flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q     <= 1'b1;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      ctrl_q      <= ctrl_d;
      rd_q        <= rd;
      reg_write_q <= reg_write_d;
      illegal_q   <= illegal_d;
    end else if (bus.i_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.o_valid       = valid_q;
  assign bus.o_alu_in1     = in1_q;
  assign bus.o_alu_in2     = in2_q;
  assign bus.o_alu_control = ctrl_q;
  assign bus.o_rd          = rd_q;
  assign bus.o_reg_write   = reg_write_q;
  assign bus.o_illegal     = illegal_q;

`ifdef ALU_ISSUE_PERF_CNT_EN
  logic [31:0] issue_cnt_q;
  logic [31:0] stall_cnt_q;

  // Issue/stall counters on the execute-side handshake; clear wins over increment
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else if (i_cnt_clr) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (valid_q && bus.i_ready) begin
        issue_cnt_q <= issue_cnt_q + 32'd1;
      end
      if (valid_q && !bus.i_ready) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign o_issue_cnt = issue_cnt_q;
  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule
